// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// ALU operation codes, datapath mux selects and the instruction classifier.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_WB_ALU    = 4'd4,
    S_ADDR      = 4'd5,
    S_MEM_RD    = 4'd6,
    S_MEM_WR    = 4'd7,
    S_WB_MEM    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP_LINK = 4'd10,
    S_JUMP_REG  = 4'd11,
    S_ILLEGAL   = 4'd12,
    S_FAULT     = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    C_RTYPE, C_JR, C_MEM, C_IMM, C_BEQ, C_JAL, C_BAD
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_SLT = 6'b101010;

  // Codes understood by the existing ALU control block.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ANDI = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_JAL  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_JR   = 4'b1111;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       retire;
  } ctrl_t;

  function automatic iclass_e decode_class(input logic [5:0] opcode, input logic [5:0] funct);
    iclass_e c;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SLL, F_AND, F_NOR, F_SLT: c = C_RTYPE;
          F_JR:                              c = C_JR;
          default:                           c = C_BAD;
        endcase
      end
      OP_LW, OP_SW:     c = C_MEM;
      OP_ADDI, OP_ANDI: c = C_IMM;
      OP_BEQ:           c = C_BEQ;
      OP_JAL:           c = C_JAL;
      default:          c = C_BAD;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] r_alu_code(input logic [5:0] funct);
    logic [3:0] code;
    case (funct)
      F_ADD:   code = ALU_ADD;
      F_SLL:   code = ALU_SLL;
      F_AND:   code = ALU_AND;
      F_NOR:   code = ALU_NOR;
      F_SLT:   code = ALU_SLT;
      default: code = ALU_JR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory port; flags the cycle in which the
// MEM_TIMEOUT-th consecutive wait completes without MemReady.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;
  logic             run;

  // Any cycle that is not an unanswered wait clears the count, which covers
  // entry into every wait state including back-to-back MEM_WR -> FETCH.
  assign run = waiting && !ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (run) count <= count + CNT_W'(1);
    else          count <= '0;
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the shared-ALU MIPS datapath: FETCH through
// writeback, with bounded memory handshakes and sticky Illegal/Fault flags.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [3:0] ALUCtl,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       Illegal,
  output logic       Fault,
  output logic       Retire
);

  state_e  state;
  iclass_e iclass;
  ctrl_t   ctrl;
  logic    waiting;
  logic    timeout;
  logic    illegal_q;
  logic    fault_q;

  // IR only changes on IRWrite in FETCH, so later states may decode it directly.
  assign iclass  = decode_class(Opcode, Funct);
  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .ready   (MemReady),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (timeout) begin
      state   <= S_FAULT;
      fault_q <= 1'b1;
    end else begin
      case (state)
        S_FETCH:  if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (iclass)
            C_RTYPE: state <= S_EXEC_R;
            C_JR:    state <= S_JUMP_REG;
            C_MEM:   state <= S_ADDR;
            C_IMM:   state <= S_EXEC_I;
            C_BEQ:   state <= S_BRANCH;
            C_JAL:   state <= S_JUMP_LINK;
            default: begin
              state     <= S_ILLEGAL;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
        S_ADDR:   state <= (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (MemReady) state <= S_WB_MEM;
        S_MEM_WR: if (MemReady) state <= S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP_LINK, S_JUMP_REG: state <= S_FETCH;
        S_ILLEGAL, S_FAULT: state <= state;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    // NOTE: every field gets its default before the case so no path can leave
    // a signal unassigned and infer a latch.
    ctrl = '0;
    // NOTE: strobes are gated by reset combinationally so they drop the moment
    // reset asserts instead of waiting for the FETCH decode to take over.
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_ctl   = ALU_ADD;
          if (MemReady) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_ALU;
          end
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_ctl   = ALU_ADD;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_RT;
          ctrl.alu_ctl   = r_alu_code(Funct);
        end
        S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_ctl   = (Opcode == OP_ANDI) ? ALU_ANDI : ALU_ADDI;
        end
        S_WB_ALU: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = M2R_ALUOUT;
          ctrl.reg_dst    = (Opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
          ctrl.retire     = 1'b1;
        end
        S_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_ctl   = (Opcode == OP_SW) ? ALU_SW : ALU_LW;
        end
        S_MEM_RD: begin
          ctrl.ior_d    = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.ior_d     = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.retire    = MemReady;
        end
        S_WB_MEM: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = M2R_MDR;
          ctrl.reg_dst    = REGDST_RT;
          ctrl.retire     = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_RT;
          ctrl.alu_ctl   = ALU_BEQ;
          ctrl.pc_write  = Zero;
          ctrl.pc_source = PC_SRC_ALUOUT;
          ctrl.retire    = 1'b1;
        end
        S_JUMP_LINK: begin
          ctrl.alu_ctl    = ALU_JAL;
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REGDST_RA;
          ctrl.mem_to_reg = M2R_PC;
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PC_SRC_JUMP;
          ctrl.retire     = 1'b1;
        end
        S_JUMP_REG: begin
          ctrl.alu_ctl   = ALU_JR;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_RS;
          ctrl.retire    = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign ALUCtl   = ctrl.alu_ctl;
  assign IorD     = ctrl.ior_d;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign PCWrite  = ctrl.pc_write;
  assign PCSource = ctrl.pc_source;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign RegWrite = ctrl.reg_write;
  assign RegDst   = ctrl.reg_dst;
  assign MemToReg = ctrl.mem_to_reg;
  assign Retire   = ctrl.retire;
  assign Illegal  = illegal_q;
  assign Fault    = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected control words
// are queued as stimulus is driven and compared at the following falling edge.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 8;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic       fault;
    logic       retire;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic [3:0] ALUCtl;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemToReg;
  logic       Illegal, Fault, Retire;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  string tag_q[$];
  obs_t observed;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .ALUCtl(ALUCtl), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .Illegal(Illegal), .Fault(Fault), .Retire(Retire)
  );

  always_comb observed = {ALUCtl, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource,
                          ALUSrcA, ALUSrcB, RegWrite, RegDst, MemToReg, Illegal, Fault, Retire};

  localparam obs_t ZERO          = '0;
  localparam obs_t E_FETCH_WAIT  = '{alu_ctl:4'b0010, mem_read:1'b1, alu_src_b:2'd1, default:'0};
  localparam obs_t E_FETCH_RDY   = '{alu_ctl:4'b0010, mem_read:1'b1, alu_src_b:2'd1,
                                     ir_write:1'b1, pc_write:1'b1, default:'0};
  localparam obs_t E_DECODE      = '{alu_ctl:4'b0010, alu_src_b:2'd3, default:'0};
  localparam obs_t E_WB_R        = '{reg_write:1'b1, reg_dst:2'd1, retire:1'b1, default:'0};
  localparam obs_t E_WB_I        = '{reg_write:1'b1, retire:1'b1, default:'0};
  localparam obs_t E_MEM_RD      = '{ior_d:1'b1, mem_read:1'b1, default:'0};
  localparam obs_t E_WB_MEM      = '{reg_write:1'b1, mem_to_reg:2'd1, retire:1'b1, default:'0};
  localparam obs_t E_MEM_WR      = '{ior_d:1'b1, mem_write:1'b1, default:'0};
  localparam obs_t E_MEM_WR_DONE = '{ior_d:1'b1, mem_write:1'b1, retire:1'b1, default:'0};
  localparam obs_t E_BR_TAKEN    = '{alu_ctl:4'b1010, alu_src_a:1'b1, pc_write:1'b1,
                                     pc_source:2'd1, retire:1'b1, default:'0};
  localparam obs_t E_BR_NOT      = '{alu_ctl:4'b1010, alu_src_a:1'b1,
                                     pc_source:2'd1, retire:1'b1, default:'0};
  localparam obs_t E_JR          = '{alu_ctl:4'b1111, pc_write:1'b1, pc_source:2'd3,
                                     retire:1'b1, default:'0};
  localparam obs_t E_ILLEGAL     = '{illegal:1'b1, default:'0};
  localparam obs_t E_FAULT       = '{fault:1'b1, default:'0};

  logic [5:0] r_funct [5] = '{6'b100000, 6'b000000, 6'b100100, 6'b100111, 6'b101010};
  logic [3:0] r_alu   [5] = '{4'b0010,   4'b0100,   4'b0000,   4'b1100,   4'b0111};

  function automatic obs_t e_exec(input logic [3:0] alu, input logic [1:0] srcb);
    obs_t o;
    o           = '0;
    o.alu_ctl   = alu;
    o.alu_src_a = 1'b1;
    o.alu_src_b = srcb;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one cycle of stimulus and queues the control word it should produce.
  task automatic step(input logic rdy, input obs_t e, input string tag);
    MemReady = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 check("reset_outputs", observed, ZERO);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    obs_t  e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, observed, e);
    end
  end

  initial begin
    reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b0;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      Opcode = 6'b000000; Funct = r_funct[i];
      step(1'b1,  E_FETCH_RDY,             "r_fetch");
      step(rnd(), E_DECODE,                "r_decode");
      step(rnd(), e_exec(r_alu[i], 2'd0),  "r_exec");
      step(rnd(), E_WB_R,                  "r_wb");
    end

    Opcode = 6'b001000; Funct = 6'b101010;
    step(1'b1,  E_FETCH_RDY,              "addi_fetch");
    step(rnd(), E_DECODE,                 "addi_decode");
    step(rnd(), e_exec(4'b0011, 2'd2),    "addi_exec");
    step(rnd(), E_WB_I,                   "addi_wb");
    Opcode = 6'b001100;
    step(1'b1,  E_FETCH_RDY,              "andi_fetch");
    step(rnd(), E_DECODE,                 "andi_decode");
    step(rnd(), e_exec(4'b0001, 2'd2),    "andi_exec");
    step(rnd(), E_WB_I,                   "andi_wb");

    Opcode = 6'b100011;
    step(1'b1,  E_FETCH_RDY,              "lw_fetch");
    step(rnd(), E_DECODE,                 "lw_decode");
    step(rnd(), e_exec(4'b1000, 2'd2),    "lw_addr");
    for (int i = 0; i < 3; i++) step(1'b0, E_MEM_RD, "lw_mem_wait");
    step(1'b1,  E_MEM_RD,                 "lw_mem_ready");
    step(rnd(), E_WB_MEM,                 "lw_wb");

    Opcode = 6'b101011;
    step(1'b1,  E_FETCH_RDY,              "sw_fetch");
    step(rnd(), E_DECODE,                 "sw_decode");
    step(rnd(), e_exec(4'b1001, 2'd2),    "sw_addr");
    step(1'b1,  E_MEM_WR_DONE,            "sw_mem_ready");
    step(1'b1,  E_FETCH_RDY,              "sw2_fetch");
    step(rnd(), E_DECODE,                 "sw2_decode");
    step(rnd(), e_exec(4'b1001, 2'd2),    "sw2_addr");
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1'b0, E_MEM_WR, "sw2_mem_wait");
    step(1'b1,  E_MEM_WR_DONE,            "sw2_ready_at_limit");

    Opcode = 6'b000000; Funct = 6'b001000;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1'b0, E_FETCH_WAIT, "jr_fetch_wait");
    step(1'b1,  E_FETCH_RDY,              "jr_ready_at_limit");
    step(rnd(), E_DECODE,                 "jr_decode");
    step(rnd(), E_JR,                     "jr_jump");

    Opcode = 6'b000100;
    Zero = 1'b1;
    step(1'b1,  E_FETCH_RDY,              "beq1_fetch");
    step(rnd(), E_DECODE,                 "beq1_decode");
    step(rnd(), E_BR_TAKEN,               "beq_taken");
    Zero = 1'b0;
    step(1'b1,  E_FETCH_RDY,              "beq0_fetch");
    step(rnd(), E_DECODE,                 "beq0_decode");
    step(rnd(), E_BR_NOT,                 "beq_not_taken");

    // jal aborted by reset in its DECODE cycle.
    Opcode = 6'b000011;
    step(1'b1, E_FETCH_RDY, "jal_fetch");
    exp_q.push_back(E_DECODE);
    tag_q.push_back("jal_decode");
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("jal_reset_async", observed, ZERO);
    @(posedge clk);
    #1 check("jal_reset_held", observed, ZERO);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, E_FETCH_WAIT, "jal_restart_fetch");

    Opcode = 6'b111111;
    step(1'b1,  E_FETCH_RDY, "ill_fetch");
    step(rnd(), E_DECODE,    "ill_decode");
    for (int i = 0; i < 21; i++) step(rnd(), E_ILLEGAL, "ill_sticky");

    do_reset();
    Opcode = 6'b000000; Funct = 6'b111111;
    step(1'b1,  E_FETCH_RDY, "badfunct_fetch");
    step(rnd(), E_DECODE,    "badfunct_decode");
    for (int i = 0; i < 3; i++) step(rnd(), E_ILLEGAL, "badfunct_illegal");

    do_reset();
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1'b0, E_FETCH_WAIT, "timeout_fetch_wait");
    for (int i = 0; i < 5; i++) step(rnd(), E_FAULT, "fault_sticky");

    do_reset();
    Funct = 6'b100000;
    step(1'b1,  E_FETCH_RDY,            "post_fault_fetch");
    step(rnd(), E_DECODE,               "post_fault_decode");
    step(rnd(), e_exec(4'b0010, 2'd0),  "post_fault_exec");
    step(rnd(), E_WB_R,                 "post_fault_wb");

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the MIPS core's shared ALU, register file and unified memory port. Steps each instruction through fetch, decode, execute, memory and writeback. Drives every datapath mux, write-enable and the 4-bit ALU operation code. Handles a ready-based memory handshake with a bounded wait.

Parameters:
MEM_TIMEOUT, 255, maximum cycles to wait for MemReady before entering FAULT (1..65535)
CNT_W, 16, width of wait counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
Opcode  input  6  instruction [31:26], from IR
Funct  input  6  instruction [5:0], from IR
Zero  input  1  ALU zero flag
MemReady  input  1  memory completed current read/write this cycle
ALUCtl  output  4  ALU operation code
IorD  output  1  0=PC addresses memory, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  latch instruction register
PCWrite  output  1  unconditional PC load
PCSource  output  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=register rs
ALUSrcA  output  1  0=PC, 1=rs
ALUSrcB  output  2  0=rt, 1=constant 4, 2=sign-ext imm, 3=sign-ext imm<<2
RegWrite  output  1  register file write enable
RegDst  output  2  0=rt, 1=rd, 2=$31
MemToReg  output  2  0=ALUOut, 1=MDR, 2=PC
Illegal  output  1  sticky: unsupported opcode/funct decoded
Fault  output  1  sticky: memory timeout
Retire  output  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset is asynchronous. It forces state FETCH, wait counter 0, Illegal=0, Fault=0. Every output is 0 during reset.
- Reset mid-instruction aborts the instruction; no register or memory write occurs afterwards.
- ALU codes: and 0000, andi 0001, add 0010, addi 0011, sll 0100, slt 0111, lw 1000, sw 1001, beq 1010, jal 1011, nor 1100, jr 1111.
- Supported opcodes: 000000 (funct 100000/000000/100100/100111/001000/101010), 100011, 101011, 001000, 001100, 000100, 000011. Anything else goes to ILLEGAL.
- States and transitions:
  - FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUCtl=0010. Stays in FETCH until MemReady. On MemReady (Mealy): IRWrite=1, PCWrite=1, PCSource=0, then go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUCtl=0010 (branch target into ALUOut). Next state by opcode:
    - R-type → EXEC_R, except jr → JUMP_REG.
    - lw/sw → ADDR.
    - addi/andi → EXEC_I.
    - beq → BRANCH.
    - jal → JUMP_LINK.
    - unsupported → ILLEGAL.
  - EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUCtl per funct. Next: WB_ALU.
  - EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUCtl 0011 or 0001. Next: WB_ALU.
  - WB_ALU: RegWrite=1, MemToReg=0, RegDst=1 for R-type and 0 for I-type. Retire=1. Next: FETCH.
  - ADDR: ALUSrcA=1, ALUSrcB=2, ALUCtl 1000 or 1001. Next: MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: IorD=1, MemRead=1. Waits for MemReady, then WB_MEM.
  - MEM_WR: IorD=1, MemWrite=1. Waits for MemReady; then Retire=1 and go to FETCH.
  - WB_MEM: RegWrite=1, MemToReg=1, RegDst=0. Retire=1. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUCtl=1010. PCWrite=Zero, PCSource=1. Retire=1. Next: FETCH.
  - JUMP_LINK: RegWrite=1, RegDst=2, MemToReg=2, PCWrite=1, PCSource=2. Retire=1. Next: FETCH.
  - JUMP_REG: ALUCtl=1111, PCWrite=1, PCSource=3. Retire=1. Next: FETCH.
  - ILLEGAL: sets Illegal. Terminal; all strobes 0 until reset.
  - FAULT: sets Fault. Terminal; all strobes 0 until reset.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle spent waiting without MemReady.
  - When it reaches MEM_TIMEOUT with MemReady still low, next state is FAULT.
  - If MemReady is asserted in the same cycle the counter reaches MEM_TIMEOUT, MemReady wins: normal transition, no fault.
- MemRead/MemWrite stay asserted and stable throughout a wait. The address source (IorD) does not change while waiting.
- Latency with MemReady tied high:
  - R/I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, jal, jr: 3 cycles.
- Never asserted together: RegWrite with MemWrite; IRWrite outside FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding (4-bit);
  - opcode and funct constants;
  - ALU code constants, matching the existing ALU control encoding;
  - mux-select constants for PCSource, ALUSrcB, RegDst and MemToReg.
- One natural sub-module: mem_wait_timer (counter, clear, MEM_TIMEOUT compare, expired output).
- The datapath mux outputs are decoded combinationally from state inside the FSM.

Test Plan:
- add (Opcode 000000, Funct 100000), MemReady=1 → states FETCH, DECODE, EXEC_R, WB_ALU. ALUCtl=0010 in EXEC_R; RegWrite=1 and RegDst=1 in cycle 4; Retire pulses once.
- lw (100011), MemReady low 3 cycles in MEM_RD → MemRead and IorD=1 held 4 cycles. WB_MEM then asserts RegWrite and MemToReg=1. No Fault.
- beq (000100) with Zero=1, then again with Zero=0 → PCWrite=1 with PCSource=1 in the first case; PCWrite=0 in the second. Both take 3 cycles.
- Opcode 111111 → ILLEGAL after DECODE. Illegal=1 and sticky; all strobes 0 for the following 20 cycles.
- MEM_TIMEOUT=8, MemReady held 0 in FETCH → Fault=1 after 8 wait cycles. Separately, MemReady on exactly cycle 8 → no fault.
- jal (000011), with reset asserted during the DECODE cycle → outputs go to 0 immediately. After release, FETCH restarts with no RegWrite ever issued.
